mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported 16-bit memory between the instruction-fetch stage
//  (read-only requester I) and the ALU/data-memory stage (read/write requester D).
//  Requests are serialised through a fixed-latency access sequence.
//  D normally wins; a streak counter guarantees fetch forward progress.
//  Sits between the pipeline stage buffers and the unified memory array.
// PARAMETERS
//  WIDTH       16  data and address width (one WORD)
//  MEM_LAT     2   cycles mem_en/address are held per access (>=1)
//  STREAK_MAX  3   consecutive D grants allowed while i_req is pending
// PORTS
//  clock      in   1      system clock, all state on posedge
//  reset      in   1      synchronous, active-low
//  i_req      in   1      fetch read request, held until i_ack
//  i_addr     in   WIDTH  fetch address
//  i_ack      out  1      one-cycle pulse: fetch access complete
//  i_rdata    out  WIDTH  fetch read data, valid with i_ack, held after
//  d_req      in   1      data request, held until d_ack
//  d_we       in   1      1 = write, 0 = read
//  d_addr     in   WIDTH  data address
//  d_wdata    in   WIDTH  write data
//  d_ack      out  1      one-cycle pulse: data access complete
//  d_rdata    out  WIDTH  data read data, valid with d_ack, held after
//  mem_en     out  1      memory access enable
//  mem_we     out  1      memory write enable
//  mem_addr   out  WIDTH  memory address
//  mem_wdata  out  WIDTH  memory write data
//  mem_rdata  in   WIDTH  memory read data, valid in last ACCESS cycle
//  busy       out  1      1 while state != IDLE
//  owner      out  1      current grant: 0 = I, 1 = D (0 in IDLE)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, streak=0, every output 0
//    (incl. i_rdata/d_rdata). Overrides everything, incl. mid-access: no ack, mem_en 0 next cycle.
//  - States: IDLE -> ACCESS -> RESP -> IDLE.
//  - IDLE: if i_req|d_req, arbitrate; latch owner, addr, we (I: we=0), wdata;
//    cnt <= MEM_LAT-1; go ACCESS. No request: stay, outputs idle (mem_* = 0).
//  - Arbitration: D wins if d_req & !(i_req & streak==STREAK_MAX); else I.
//    streak: +1 (saturating) on D grant with i_req=1; cleared on I grant or
//    on D grant with i_req=0.
//  - ACCESS: mem_en=1, mem_addr/mem_we/mem_wdata from latched copy (mem_wdata=0
//    for reads). Requester addr/data changes ignored. cnt==0: on read, capture
//    mem_rdata into owner's rdata; go RESP. Else cnt--.
//  - RESP: mem_en=0; owner's ack=1 for exactly this cycle; go IDLE.
//  - Latency: request sampled in IDLE cycle T -> mem_en cycles T+1..T+MEM_LAT
//    -> ack in T+MEM_LAT+1. Throughput: one access per MEM_LAT+2 cycles.
//  - Requester may keep req high past ack; the following IDLE cycle treats it
//    as a new request (back-to-back allowed, re-arbitrated).
//  - Write: mem_we=1 for all MEM_LAT cycles; d_ack pulses; d_rdata unchanged.
//  - req dropped during ACCESS: access still completes and ack still pulses.
//  - i_ack and d_ack never high in the same cycle; owner stable from ACCESS entry through RESP.
//  - cnt width = $clog2(MEM_LAT)+1; no wrap (loaded fresh each access).
// TESTING
//  1 reset=0 for 2 cycles, i_req=d_req=1 -> all outputs 0, no mem_en.
//  2 i_req, i_addr=0x0010, mem_rdata=0xBEEF -> mem_en cycles 1-2 addr 0x0010,
//    i_ack cycle 3, i_rdata=0xBEEF held after.
//  3 i_req & d_req same cycle, d read 0x0020 -> D served first (owner=1),
//    then I; acks never overlap.
//  4 d_we=1 0x0030<=0x1234 -> mem_we=1, mem_wdata=0x1234 for 2 cycles; d_ack;
//    d_rdata unchanged.
//  5 i_req and d_req held high continuously -> grant order D,D,D,I,D,D,D,I.
//  6 reset=0 during 2nd ACCESS cycle -> no ack, mem_en=0 next cycle; new i_req
//    afterwards completes normally in MEM_LAT+1 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between fetch (read-only) and data (read/write) requesters.
// Latency: request seen in IDLE -> MEM_LAT mem_en cycles -> one-cycle ack; one access per MEM_LAT+2 cycles.
// Backpressure: requesters hold req until their ack; D has priority, bounded by STREAK_MAX while fetch waits.
module mem_port_arbiter #(
    parameter int WIDTH      = 16,
    parameter int MEM_LAT    = 2,
    parameter int STREAK_MAX = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_addr,
    output logic             i_ack,
    output logic [WIDTH-1:0] i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_ack,
    output logic [WIDTH-1:0] d_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy,
    output logic             owner
);

    localparam int CW = $clog2(MEM_LAT) + 1;
    localparam int SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [SW-1:0]    streak, streak_nxt;
    logic             take;
    logic             grant_d;
    logic             capture;

    logic             lat_owner;
    logic             lat_we;
    logic [WIDTH-1:0] lat_addr;
    logic [WIDTH-1:0] lat_wdata;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        streak_nxt = streak;
        take       = 1'b0;
        grant_d    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    take    = 1'b1;
                    // A fetch that has waited out STREAK_MAX data grants wins the next slot.
                    grant_d = d_req && !(i_req && (streak == SW'(STREAK_MAX)));
                    if (grant_d && i_req) begin
                        streak_nxt = (streak == SW'(STREAK_MAX)) ? streak : streak + SW'(1);
                    end else begin
                        streak_nxt = '0;
                    end
                    cnt_nxt   = CW'(MEM_LAT - 1);
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt       <= '0;
            streak    <= '0;
            lat_owner <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            cnt    <= cnt_nxt;
            streak <= streak_nxt;
            if (take) begin
                lat_owner <= grant_d;
                lat_we    <= grant_d && d_we;
                lat_addr  <= grant_d ? d_addr : i_addr;
                lat_wdata <= (grant_d && d_we) ? d_wdata : '0;
            end
            if (capture && !lat_we) begin
                if (lat_owner) begin
                    d_rdata <= mem_rdata;
                end else begin
                    i_rdata <= mem_rdata;
                end
            end
        end
    end

    assign busy      = (state != IDLE);
    assign owner     = busy && lat_owner;
    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en && lat_we;
    assign mem_addr  = mem_en ? lat_addr : '0;
    assign mem_wdata = mem_en ? lat_wdata : '0;
    assign i_ack     = (state == RESP) && !lat_owner;
    assign d_ack     = (state == RESP) && lat_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack;
    logic [15:0] i_rdata, d_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, owner;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.WIDTH(16), .MEM_LAT(2), .STREAK_MAX(3)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits up to 12 falling edges for an ack; n is the edge count at which it appeared.
    task automatic wait_ack(output logic is_d, output int n);
        logic found;
        found = 1'b0;
        is_d  = 1'b0;
        n     = 0;
        for (int k = 1; k <= 12 && !found; k++) begin
            @(negedge clock);
            if (i_ack || d_ack) begin
                found = 1'b1;
                n     = k;
                is_d  = d_ack;
                chk("ack_excl", {31'b0, i_ack & d_ack}, 32'd0);
            end
        end
        if (!found) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    logic is_d;
    int   n;
    logic exp_order [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        reset = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

        // 1: reset holds everything idle despite requests
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
            chk("rst_busy",   {31'b0, busy},   32'd0);
            chk("rst_acks",   {30'b0, i_ack, d_ack}, 32'd0);
            chk("rst_owner",  {31'b0, owner},  32'd0);
            chk("rst_rdata",  {i_rdata, d_rdata}, 32'd0);
            chk("rst_mem_bus", {mem_addr, mem_wdata}, 32'd0);
        end
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0;

        // 2: single fetch read
        @(negedge clock);
        i_req = 1'b1; i_addr = 16'h0010; mem_rdata = 16'hBEEF;
        @(negedge clock);
        chk("f_en1",   {31'b0, mem_en}, 32'd1);
        chk("f_addr1", {16'b0, mem_addr}, 32'h0010);
        chk("f_own1",  {31'b0, owner}, 32'd0);
        chk("f_we1",   {15'b0, mem_we, mem_wdata}, 32'd0);
        i_addr = 16'h0099;
        @(negedge clock);
        chk("f_en2",   {31'b0, mem_en}, 32'd1);
        chk("f_addr2", {16'b0, mem_addr}, 32'h0010);
        chk("f_ack_early", {31'b0, i_ack}, 32'd0);
        @(negedge clock);
        chk("f_ack",   {31'b0, i_ack}, 32'd1);
        chk("f_en3",   {31'b0, mem_en}, 32'd0);
        chk("f_rdata", {16'b0, i_rdata}, 32'hBEEF);
        i_req = 1'b0;
        @(negedge clock);
        chk("f_ack_pulse", {31'b0, i_ack}, 32'd0);
        chk("f_idle", {31'b0, busy}, 32'd0);
        chk("f_hold", {16'b0, i_rdata}, 32'hBEEF);

        // 3: simultaneous requests, D first then I
        i_req = 1'b1; i_addr = 16'h0040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020; mem_rdata = 16'h5A5A;
        @(negedge clock);
        chk("both_owner", {31'b0, owner}, 32'd1);
        chk("both_addr",  {16'b0, mem_addr}, 32'h0020);
        wait_ack(is_d, n);
        chk("both_first_d", {31'b0, is_d}, 32'd1);
        chk("both_first_n", n, 32'd2);
        chk("both_d_rdata", {16'b0, d_rdata}, 32'h5A5A);
        d_req = 1'b0; mem_rdata = 16'h1111;
        wait_ack(is_d, n);
        chk("both_second_i", {31'b0, is_d}, 32'd0);
        chk("both_second_n", n, 32'd4);
        chk("both_i_rdata", {i_rdata, d_rdata}, 32'h11115A5A);
        i_req = 1'b0;
        @(negedge clock);

        // 4: data write leaves d_rdata alone
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h1234; mem_rdata = 16'hFFFF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk("wr_we_en", {30'b0, mem_en, mem_we}, 32'd3);
            chk("wr_bus",   {mem_addr, mem_wdata}, 32'h00301234);
        end
        @(negedge clock);
        chk("wr_ack",   {30'b0, d_ack, mem_we}, 32'd2);
        chk("wr_rdata", {16'b0, d_rdata}, 32'h5A5A);
        d_we = 1'b0;

        // 5: both held: streak limit lets fetch through every fourth grant
        i_req = 1'b1; i_addr = 16'h0050; d_addr = 16'h0060;
        for (int g = 0; g < 8; g++) begin
            wait_ack(is_d, n);
            chk($sformatf("order_%0d", g), {31'b0, is_d}, {31'b0, exp_order[g]});
            chk($sformatf("order_n_%0d", g), n, 32'd4);
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clock);
        chk("post_order_idle", {31'b0, busy}, 32'd0);

        // 6: reset during second ACCESS cycle aborts the access
        i_req = 1'b1; i_addr = 16'h0070; mem_rdata = 16'h7777;
        @(negedge clock);
        @(negedge clock);
        chk("abort_pre_en", {31'b0, mem_en}, 32'd1);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_en",    {31'b0, mem_en}, 32'd0);
        chk("abort_ack",   {30'b0, i_ack, d_ack}, 32'd0);
        chk("abort_rdata", {i_rdata, d_rdata}, 32'd0);
        reset = 1'b1;
        wait_ack(is_d, n);
        chk("resume_i",     {31'b0, is_d}, 32'd0);
        chk("resume_n",     n, 32'd3);
        chk("resume_rdata", {16'b0, i_rdata}, 32'h7777);
        i_req = 1'b0;
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
